// File: rtl/ir_fusion_if.sv
// ir_fusion_if: IR sample, derivative and heading bundle between the sensor front end and ir_fusion.
interface ir_fusion_if #(
    parameter int W = 12
);
    logic                  ir_vld;
    logic                  lft_opn;
    logic                  rght_opn;
    logic        [W-1:0]   lft_IR;
    logic        [W-1:0]   rght_IR;
    logic signed [W-4:0]   IR_Dtrm;
    logic                  en_fusion;
    logic signed [W-1:0]   dsrd_hdng;
    logic signed [W-1:0]   dsrd_hdng_adj;
    logic                  adj_vld;
    logic                  fill;
    modport master (
        output ir_vld, lft_opn, rght_opn, lft_IR, rght_IR, IR_Dtrm, en_fusion, dsrd_hdng,
        input  dsrd_hdng_adj, adj_vld, fill
    );
    modport slave (
        input  ir_vld, lft_opn, rght_opn, lft_IR, rght_IR, IR_Dtrm, en_fusion, dsrd_hdng,
        output dsrd_hdng_adj, adj_vld, fill
    );
endinterface

// File: rtl/ir_fusion.sv
// ir_fusion: moving average of IR wall error fused with IR_Dtrm into the desired heading.
// Define IR_FUSION_SAT_EN to clamp the correction to +/-(2^(W-3)-1) before the heading add.
module ir_fusion #(
    parameter int             W        = 12,
    parameter logic [W-1:0]   NOM_IR   = 12'h970,
    parameter int             AVG_LOG2 = 2
) (
    input logic        clk,
    input logic        rst_n,
    ir_fusion_if.slave bus
);
    localparam int D  = 1 << AVG_LOG2;
    localparam int PW = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
    localparam int SW = W + 1 + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;

    typedef enum logic [1:0] {EMPTY, FILL, RUN} state_t;

    state_t              state, state_nxt;
    logic signed [W:0]   buf_q [D];
    logic signed [W:0]   l_x, r_x, n_x, half, err, oldest, avg, dt_x, corr_raw, corr;
    logic signed [SW-1:0] sum, sum_nxt;
    logic [PW-1:0]       wptr, wptr_nxt, base_ptr;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic [1:0]          opn_q;
    logic                flush, wr, v1;

    assign l_x  = {1'b0, bus.lft_IR};
    assign r_x  = {1'b0, bus.rght_IR};
    assign n_x  = {1'b0, NOM_IR};
    assign half = (l_x - r_x) >>> 1;
    assign err  = bus.lft_opn && bus.rght_opn ? '0 :
                  bus.lft_opn ? n_x - r_x :
                  bus.rght_opn ? l_x - n_x : half;

    assign dt_x     = (W+1)'(bus.IR_Dtrm);
    assign corr_raw = ((avg >>> 5) + (dt_x <<< 2)) >>> 1;
`ifdef IR_FUSION_SAT_EN
    localparam logic signed [W:0] LIM = (W+1)'(2 ** (W - 3) - 1);
    assign corr = corr_raw > LIM ? LIM : corr_raw < -LIM ? -LIM : corr_raw;
`else
    assign corr = corr_raw;
`endif

    assign bus.fill = state == RUN;

    // A flush empties the window first so a coinciding sample lands as its first entry.
    always_comb begin
        flush     = !bus.en_fusion || (bus.ir_vld && {bus.lft_opn, bus.rght_opn} != opn_q);
        wr        = bus.ir_vld && bus.en_fusion;
        base_ptr  = flush ? '0 : wptr;
        oldest    = flush ? '0 : buf_q[base_ptr];
        sum_nxt   = flush ? '0 : sum;
        cnt_nxt   = flush ? '0 : cnt;
        wptr_nxt  = base_ptr;
        if (wr) begin
            sum_nxt  = sum_nxt + SW'(err) - SW'(oldest);
            wptr_nxt = base_ptr == PW'(D - 1) ? '0 : base_ptr + 1'b1;
            cnt_nxt  = cnt_nxt == CW'(D) ? cnt_nxt : cnt_nxt + 1'b1;
        end
        state_nxt = cnt_nxt == CW'(D) ? RUN : cnt_nxt != '0 ? FILL : EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum               <= '0;
            wptr              <= '0;
            cnt               <= '0;
            opn_q             <= '0;
            avg               <= '0;
            v1                <= 1'b0;
            bus.adj_vld       <= 1'b0;
            bus.dsrd_hdng_adj <= '0;
            for (int i = 0; i < D; i++) buf_q[i] <= '0;
        end else begin
            sum  <= sum_nxt;
            wptr <= wptr_nxt;
            cnt  <= cnt_nxt;
            avg  <= (W+1)'(sum_nxt >>> AVG_LOG2);
            if (bus.ir_vld) opn_q <= {bus.lft_opn, bus.rght_opn};
            for (int i = 0; i < D; i++) if (flush) buf_q[i] <= '0;
            if (wr) buf_q[base_ptr] <= err;
            v1                <= wr;
            bus.adj_vld       <= v1 && bus.en_fusion;
            bus.dsrd_hdng_adj <= bus.en_fusion ? bus.dsrd_hdng + corr[W-1:0] : bus.dsrd_hdng;
        end
    end
endmodule

// File: tb/tb_ir_fusion.sv
// tb_ir_fusion: directed vector table, corner sequences and randomized traffic against a window model.
module tb_ir_fusion;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    ir_fusion_if #(.W(12)) bus ();
    ir_fusion #(.W(12), .NOM_IR(12'h970), .AVG_LOG2(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int m_q[$];
    int m_avg;
    bit [1:0] m_opn;
    bit m_v1;
    int e_adj, e_vld, e_fill;

    typedef struct {
        bit en, vld, lo, ro;
        logic [11:0] l, r;
        int dt;
        logic [11:0] hd, adj;
        bit av, fl;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int err_f(int l, int r, bit lo, bit ro);
        if (lo && ro) return 0;
        if (lo) return 2416 - r;
        if (ro) return l - 2416;
        return (l - r) >>> 1;
    endfunction

    function automatic int corr_f(int a, int d);
        int c;
        c = ((a >>> 5) + d * 4) >>> 1;
`ifdef IR_FUSION_SAT_EN
        if (c > 511) c = 511;
        if (c < -511) c = -511;
`endif
        return c;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_avg = 0; m_opn = 0; m_v1 = 0;
        e_adj = 0; e_vld = 0; e_fill = 0;
    endtask

    task automatic model_step();
        bit en, vld, flush;
        bit [1:0] opn;
        int hd, s;
        en  = bus.en_fusion;
        vld = bus.ir_vld;
        opn = {bus.lft_opn, bus.rght_opn};
        hd  = int'(bus.dsrd_hdng) & 'hFFF;
        e_adj = en ? (hd + corr_f(m_avg, int'(bus.IR_Dtrm))) & 'hFFF : hd;
        e_vld = int'(m_v1 && en);
        m_v1  = vld && en;
        flush = !en || (vld && opn != m_opn);
        if (flush) m_q.delete();
        if (vld && en) begin
            m_q.push_back(err_f(int'(bus.lft_IR), int'(bus.rght_IR), opn[1], opn[0]));
            if (m_q.size() > D) void'(m_q.pop_front());
        end
        if (vld) m_opn = opn;
        s = 0;
        foreach (m_q[i]) s += m_q[i];
        m_avg  = s >>> 2;
        e_fill = int'(m_q.size() == D);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("model_adj", int'(bus.dsrd_hdng_adj) & 'hFFF, e_adj);
        chk("model_adj_vld", int'(bus.adj_vld), e_vld);
        chk("model_fill", int'(bus.fill), e_fill);
    endtask

    task automatic drive(bit en, bit vld, bit lo, bit ro, logic [11:0] l, logic [11:0] r,
                         int dt, logic [11:0] hd);
        bus.en_fusion = en;
        bus.ir_vld    = vld;
        bus.lft_opn   = lo;
        bus.rght_opn  = ro;
        bus.lft_IR    = l;
        bus.rght_IR   = r;
        bus.IR_Dtrm   = 9'(dt);
        bus.dsrd_hdng = hd;
    endtask

    initial begin
        tbl[0] = '{1, 1, 0, 0, 12'hA70, 12'h870, 0, 12'h100, 12'h100, 0, 0};
        tbl[1] = '{1, 1, 0, 0, 12'hA70, 12'h870, 0, 12'h100, 12'h101, 1, 0};
        tbl[2] = '{1, 1, 0, 0, 12'hA70, 12'h870, 0, 12'h100, 12'h102, 1, 0};
        tbl[3] = '{1, 1, 0, 0, 12'hA70, 12'h870, 0, 12'h100, 12'h103, 1, 1};
        tbl[4] = '{1, 0, 0, 0, 12'hA70, 12'h870, 0, 12'h100, 12'h104, 1, 1};
        tbl[5] = '{1, 0, 0, 0, 12'hA70, 12'h870, 0, 12'h100, 12'h104, 0, 1};
        tbl[6] = '{0, 0, 0, 0, 12'hA70, 12'h870, 0, 12'h7FF, 12'h7FF, 0, 0};
        tbl[7] = '{1, 0, 0, 0, 12'hA70, 12'h870, 2, 12'h7FF, 12'h803, 0, 0};

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_adj", int'(bus.dsrd_hdng_adj), 0);
        chk("reset_adj_vld", int'(bus.adj_vld), 0);
        chk("reset_fill", int'(bus.fill), 0);
        rst_n = 1'b1;

        foreach (tbl[k]) begin
            drive(tbl[k].en, tbl[k].vld, tbl[k].lo, tbl[k].ro, tbl[k].l, tbl[k].r, tbl[k].dt, tbl[k].hd);
            cyc();
            chk($sformatf("vec%0d_adj", k), int'(bus.dsrd_hdng_adj) & 'hFFF, int'(tbl[k].adj));
            chk($sformatf("vec%0d_adj_vld", k), int'(bus.adj_vld), int'(tbl[k].av));
            chk($sformatf("vec%0d_fill", k), int'(bus.fill), int'(tbl[k].fl));
        end

        // Full-scale window, then a large derivative term exercises the clamp.
        repeat (4) begin
            drive(1, 1, 0, 0, 12'hFFF, 12'h000, 0, 12'h000);
            cyc();
        end
        chk("full_fill", int'(bus.fill), 1);
        drive(1, 0, 0, 0, 12'hFFF, 12'h000, 255, 12'h000);
        cyc();
`ifdef IR_FUSION_SAT_EN
        chk("sat_corr", int'(bus.dsrd_hdng_adj), 511);
`else
        chk("sat_corr", int'(bus.dsrd_hdng_adj), 541);
`endif

        // Left wall disappears while running: window restarts with this sample alone.
        drive(1, 1, 1, 0, 12'h000, 12'h770, 0, 12'h000);
        cyc();
        chk("opn_flush_fill", int'(bus.fill), 0);
        drive(1, 0, 1, 0, 12'h000, 12'h770, 0, 12'h000);
        cyc();
        chk("opn_flush_adj", int'(bus.dsrd_hdng_adj), 2);

        // Asynchronous reset in the middle of filling.
        repeat (2) begin
            drive(1, 1, 0, 0, 12'hA70, 12'h870, 0, 12'h123);
            cyc();
        end
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_adj", int'(bus.dsrd_hdng_adj), 0);
        chk("midreset_adj_vld", int'(bus.adj_vld), 0);
        chk("midreset_fill", int'(bus.fill), 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 1, 0, 0, 12'hA70, 12'h870, 0, 12'h100);
        cyc();
        chk("restart_fill", int'(bus.fill), 0);
        drive(1, 0, 0, 0, 12'hA70, 12'h870, 0, 12'h100);
        cyc();
        chk("restart_adj", int'(bus.dsrd_hdng_adj), 12'h101);
        chk("restart_adj_vld", int'(bus.adj_vld), 1);

        begin
            bit lo = 0, ro = 0;
            for (int n = 0; n < 400; n++) begin
                if ($urandom_range(0, 9) == 0) {lo, ro} = 2'($urandom);
                drive($urandom_range(0, 19) != 0, 1'($urandom), lo, ro, 12'($urandom), 12'($urandom),
                      int'($urandom_range(0, 511)) - 256, 12'($urandom));
                cyc();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
